// File: rtl/en_reg_pipe_bank.sv
// Purpose: bank of CHANNELS independent enabled shift pipelines with cross-channel reduction, fill tracking and an optional update counter.
// Latency: d->q is DEPTH enabled cycles per channel; q_red is combinational from q; valid is derived from registered fill state.
// Backpressure: none; a channel with en low simply holds, and clr (priority over en) empties every channel. Macro EN_REG_BANK_UPD_CNT_EN adds upd_cnt.
module en_reg_pipe_bank #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [1:0]                mode,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [WIDTH-1:0]          q_red,
  output logic                      valid,
  output logic [CNT_W-1:0]          upd_cnt
);

  // Fill counter only needs to reach DEPTH, where it parks.
  localparam int                FILL_W   = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [CHANNELS-1:0] full;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]  stg [DEPTH];
    logic [FILL_W-1:0] fill_cnt;

    // Shift the channel forward only on its own enable; hold otherwise, no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
        fill_cnt <= '0;
      end else if (clr) begin
        for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
        fill_cnt <= '0;
      end else if (en[c]) begin
        stg[0] <= d[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FILL_W'(1);
      end
    end

    assign q[c*WIDTH +: WIDTH] = stg[DEPTH-1];
    assign full[c]             = (fill_cnt == FILL_MAX);
  end

  // Sticky until clr/reset because fill counters never decrement.
  assign valid = &full;

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;

  // Bitwise reduction across channels, selected by mode with no register stage.
  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      red_and = red_and & q[c*WIDTH +: WIDTH];
      red_or  = red_or  | q[c*WIDTH +: WIDTH];
      red_xor = red_xor ^ q[c*WIDTH +: WIDTH];
    end
    case (mode)
      2'b00:   q_red = red_and;
      2'b01:   q_red = red_or;
      2'b10:   q_red = red_xor;
      default: q_red = q[WIDTH-1:0];
    endcase
  end

`ifdef EN_REG_BANK_UPD_CNT_EN
  // Count cycles where any channel advanced; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt <= '0;
    end else if (clr) begin
      upd_cnt <= '0;
    end else if ((|en) && (upd_cnt != {CNT_W{1'b1}})) begin
      upd_cnt <= upd_cnt + CNT_W'(1);
    end
  end
`else
  assign upd_cnt = '0;
`endif

endmodule
